// File: rtl/iir_coeff_loader.sv
// Double-buffered coefficient bank for the 2nd-order IIR filter: GPIO writes land in shadow,
// and a commit copies the whole bank to the active outputs at a sample boundary, optionally followed by a filter clear.
module iir_coeff_loader #(
    parameter int COEFF_WIDTH  = 32,
    parameter logic [COEFF_WIDTH-1:0] DEFAULT_B0   = COEFF_WIDTH'(2 ** (COEFF_WIDTH - 2)),
    parameter logic [COEFF_WIDTH-1:0] DEFAULT_GAIN = COEFF_WIDTH'(65536),
    parameter int TICK_TIMEOUT = 1024,
    parameter int FLUSH_CYCLES = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req,
    input  logic [2:0]             wr_addr,
    input  logic [COEFF_WIDTH-1:0] wr_data,
    input  logic                   commit_req,
    input  logic                   clear_on_commit,
    input  logic                   sample_tick,
    output logic [COEFF_WIDTH-1:0] b0,
    output logic [COEFF_WIDTH-1:0] b1,
    output logic [COEFF_WIDTH-1:0] b2,
    output logic [COEFF_WIDTH-1:0] a1,
    output logic [COEFF_WIDTH-1:0] a2,
    output logic [COEFF_WIDTH-1:0] gain,
    output logic                   pending,
    output logic                   filter_clr,
    output logic                   wr_err,
    output logic [CNT_WIDTH-1:0]   commit_cnt
);

    localparam int NUM_COEFF = 6;
    localparam int TMR_MAX   = (TICK_TIMEOUT > FLUSH_CYCLES) ? TICK_TIMEOUT : FLUSH_CYCLES;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_APPLY, S_FLUSH} state_t;

    function automatic logic [COEFF_WIDTH-1:0] reset_coeff(input int idx);
        if (idx == 0)      return DEFAULT_B0;
        else if (idx == 5) return DEFAULT_GAIN;
        else               return '0;
    endfunction

    state_t                 state_q, state_d;
    logic [COEFF_WIDTH-1:0] shadow_q [NUM_COEFF];
    logic [COEFF_WIDTH-1:0] active_q [NUM_COEFF];
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   clr_flag_q, clr_flag_d;
    logic                   pending_q, pending_d;
    logic                   filter_clr_q, filter_clr_d;
    logic                   wr_err_q, wr_err_d;
    logic [CNT_WIDTH-1:0]   commit_cnt_q;
    logic                   wr_req_q, commit_req_q;
    logic                   armed_q;
    logic                   wr_edge, commit_edge, do_apply, addr_bad;

    // armed_q masks the first post-reset cycle so a level held high across reset release is not an edge.
    assign wr_edge     = armed_q & wr_req & ~wr_req_q;
    assign commit_edge = armed_q & commit_req & ~commit_req_q;
    assign addr_bad    = (wr_addr > 3'd5);
    assign do_apply    = (state_q == S_APPLY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (commit_edge) state_d = S_PENDING;
            S_PENDING: if (sample_tick || tmr_q == '0) state_d = S_APPLY;
            S_APPLY:   state_d = clr_flag_q ? S_FLUSH : S_IDLE;
            S_FLUSH:   if (tmr_q == '0) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tmr_d      = tmr_q;
        clr_flag_d = clr_flag_q;
        case (state_q)
            S_IDLE: begin
                if (commit_edge) begin
                    tmr_d      = TMR_W'(TICK_TIMEOUT - 1);
                    clr_flag_d = clear_on_commit;
                end
            end
            S_PENDING: if (!sample_tick && tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
            S_APPLY:   tmr_d = TMR_W'(FLUSH_CYCLES - 1);
            S_FLUSH:   if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
            default:   tmr_d = '0;
        endcase
        pending_d    = (state_d == S_PENDING) || (state_d == S_APPLY);
        filter_clr_d = (state_d == S_FLUSH);
        // A fresh bad-address write outranks the clear that APPLY performs.
        if (wr_edge && addr_bad) wr_err_d = 1'b1;
        else if (do_apply)       wr_err_d = 1'b0;
        else                     wr_err_d = wr_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                shadow_q[i] <= reset_coeff(i);
                active_q[i] <= reset_coeff(i);
            end
            tmr_q        <= '0;
            clr_flag_q   <= 1'b0;
            pending_q    <= 1'b0;
            filter_clr_q <= 1'b0;
            wr_err_q     <= 1'b0;
            commit_cnt_q <= '0;
            wr_req_q     <= 1'b0;
            commit_req_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                if (wr_edge && wr_addr == 3'(i)) shadow_q[i] <= wr_data;
                if (do_apply)                    active_q[i] <= shadow_q[i];
            end
            if (do_apply) commit_cnt_q <= commit_cnt_q + CNT_WIDTH'(1);
            tmr_q        <= tmr_d;
            clr_flag_q   <= clr_flag_d;
            pending_q    <= pending_d;
            filter_clr_q <= filter_clr_d;
            wr_err_q     <= wr_err_d;
            wr_req_q     <= wr_req;
            commit_req_q <= commit_req;
            armed_q      <= 1'b1;
        end
    end

    assign b0         = active_q[0];
    assign b1         = active_q[1];
    assign b2         = active_q[2];
    assign a1         = active_q[3];
    assign a2         = active_q[4];
    assign gain       = active_q[5];
    assign pending    = pending_q;
    assign filter_clr = filter_clr_q;
    assign wr_err     = wr_err_q;
    assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader: reset defaults, shadow/active handoff, tick timeout, flush pulse, error flag, async reset.
module tb_iir_coeff_loader;

    localparam logic [31:0] DEF_B0   = 32'd1073741824;
    localparam logic [31:0] DEF_GAIN = 32'd65536;
    localparam logic [31:0] A2_VAL   = 32'hFFFF_FED4;  // -300
    localparam int          TMO      = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [31:0] wr_data = 32'd0;
    logic        commit_req = 1'b0;
    logic        clear_on_commit = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] b0, b1, b2, a1, a2, gain;
    logic        pending, filter_clr, wr_err;
    logic [15:0] commit_cnt;

    int checks = 0;
    int failures = 0;
    int n;
    int guard;

    iir_coeff_loader dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_req(commit_req), .clear_on_commit(clear_on_commit), .sample_tick(sample_tick),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .gain(gain),
        .pending(pending), .filter_clr(filter_clr), .wr_err(wr_err), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic shadow_write(input logic [2:0] addr, input logic [31:0] data);
        wr_addr = addr;
        wr_data = data;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        tick();
    endtask

    task automatic commit(input logic clr);
        commit_req      = 1'b1;
        clear_on_commit = clr;
        tick();
        commit_req      = 1'b0;
        clear_on_commit = 1'b0;
    endtask

    initial begin
        // Reset with wr_req held high across release; the b0=99 write must never land.
        wr_req  = 1'b1;
        wr_addr = 3'd0;
        wr_data = 32'd99;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        wr_req = 1'b0;
        tick();
        check("rst_b0", b0, DEF_B0);
        check("rst_gain", gain, DEF_GAIN);
        check("rst_b1", b1, 0);
        check("rst_a2", a2, 0);
        check("rst_pending", pending, 0);
        check("rst_cnt", commit_cnt, 0);
        check("rst_clr", filter_clr, 0);
        check("rst_err", wr_err, 0);

        // Basic commit with sample_tick five cycles after the commit edge.
        shadow_write(3'd1, 32'd12345);
        shadow_write(3'd4, A2_VAL);
        shadow_write(3'd5, 32'd131072);
        commit(1'b0);
        check("t2_pending_up", pending, 1);
        check("t2_b1_hold0", b1, 0);
        repeat (4) begin
            tick();
            check("t2_b1_hold", b1, 0);
        end
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        check("t2_apply_pending", pending, 1);
        check("t2_apply_b1_old", b1, 0);
        tick();
        check("t2_b0", b0, DEF_B0);
        check("t2_b1", b1, 12345);
        check("t2_b2", b2, 0);
        check("t2_a1", a1, 0);
        check("t2_a2", a2, A2_VAL);
        check("t2_gain", gain, 131072);
        check("t2_cnt", commit_cnt, 1);
        check("t2_pending_down", pending, 0);

        // Timeout: no sample_tick at all; pending spans TMO cycles in PENDING plus the APPLY cycle.
        shadow_write(3'd2, 32'd777);
        commit(1'b0);
        n = 0;
        while (pending === 1'b1 && n < 3000) begin
            if (b2 !== 32'd0) break;
            tick();
            n++;
        end
        check("t3_pending_cycles", n, TMO + 1);
        check("t3_b2", b2, 777);
        check("t3_cnt", commit_cnt, 2);

        // Commit with clear: eight-cycle filter_clr right after APPLY; a commit during FLUSH is dropped.
        shadow_write(3'd3, 32'd55);
        commit(1'b1);
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        check("t4_clr_in_apply", filter_clr, 0);
        tick();
        check("t4_clr_first", filter_clr, 1);
        check("t4_a1", a1, 55);
        check("t4_cnt_apply", commit_cnt, 3);
        n = 0;
        guard = 0;
        while (filter_clr === 1'b1 && guard < 50) begin
            n++;
            if (n == 2) commit_req = 1'b1;
            if (n == 4) commit_req = 1'b0;
            tick();
            guard++;
        end
        check("t4_clr_len", n, 8);
        repeat (TMO + 20) tick();
        check("t4_no_requeue_pending", pending, 0);
        check("t4_cnt_after", commit_cnt, 3);

        // Invalid address sets wr_err without touching coefficients.
        wr_addr = 3'd7;
        wr_data = 32'd5;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        check("t5_err_set", wr_err, 1);
        tick();
        check("t5_err_sticky", wr_err, 1);
        check("t5_b0_same", b0, DEF_B0);
        check("t5_gain_same", gain, 131072);

        // Shadow write coincident with the APPLY copy reaches active only on the next commit.
        commit(1'b0);
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        wr_addr = 3'd0;
        wr_data = 32'd42;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        check("t5_b0_old_shadow", b0, DEF_B0);
        check("t5_err_cleared", wr_err, 0);
        check("t5_cnt", commit_cnt, 4);
        tick();

        // Bad-address write on the APPLY edge: set beats clear; b0=42 now applies.
        commit(1'b0);
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        wr_addr = 3'd6;
        wr_data = 32'd1;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        check("t5_b0_new", b0, 42);
        check("t5_err_set_wins", wr_err, 1);
        check("t5_cnt2", commit_cnt, 5);
        tick();

        // Async reset while PENDING: defaults immediately, queued commit discarded.
        shadow_write(3'd2, 32'd999);
        commit(1'b0);
        check("t6_pending_before", pending, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_pending", pending, 0);
        check("t6_async_b0", b0, DEF_B0);
        check("t6_async_b1", b1, 0);
        check("t6_async_gain", gain, DEF_GAIN);
        check("t6_async_cnt", commit_cnt, 0);
        check("t6_async_err", wr_err, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < TMO + 50; i++) begin
            sample_tick = (i % 16 == 3);
            tick();
        end
        sample_tick = 1'b0;
        check("t6_no_apply_cnt", commit_cnt, 0);
        check("t6_no_apply_b2", b2, 0);
        check("t6_no_pending", pending, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
